// File: rtl/wb_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_if
// Bundles the writeback-stage inputs (MEM/WB register outputs), the decode
// read ports and the forwarding/debug outputs of wb_regfile.
//   master : the pipeline side (drives MEM/WB fields and read addresses)
//   slave  : the register file (returns read data, result and debug count)
// Parameters DATA_W / ADDR_W / COUNT_W must match those of wb_regfile.
// ---------------------------------------------------------------------------
interface wb_regfile_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int COUNT_W = 32
);
    logic              RegWriteW;
    logic              MemtoRegW;
    logic              LinkW;
    logic [ADDR_W-1:0] WriteRegW;
    logic [DATA_W-1:0] ReadDataW;
    logic [DATA_W-1:0] ALUOutW;
    logic [DATA_W-1:0] RB_PCPlus4;
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic [DATA_W-1:0] ResultW;
    logic [ADDR_W-1:0] WriteDstW;
    logic              WeW;
    logic [COUNT_W-1:0] wb_count;

    modport master (
        output RegWriteW, MemtoRegW, LinkW, WriteRegW,
        output ReadDataW, ALUOutW, RB_PCPlus4, A1, A2,
        input  RD1, RD2, ResultW, WriteDstW, WeW, wb_count
    );

    modport slave (
        input  RegWriteW, MemtoRegW, LinkW, WriteRegW,
        input  ReadDataW, ALUOutW, RB_PCPlus4, A1, A2,
        output RD1, RD2, ResultW, WriteDstW, WeW, wb_count
    );
endinterface

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Writeback stage plus architectural register file of the 5-stage MIPS
// pipeline. Selects the writeback result (Link > MemtoReg > ALU), commits it
// to a 2**ADDR_W x DATA_W register file on the rising edge, and serves two
// combinational decode read ports with same-cycle write-through bypass.
// Register 0 is hard-wired to zero. wb_count counts committed writes and
// saturates at all-ones.
// Ports:
//   clk    in  clock, all state updates on the rising edge
//   rst_n  in  asynchronous active-low reset; clears registers and wb_count
//   bus    slave modport of wb_regfile_if:
//            in : RegWriteW, MemtoRegW, LinkW, WriteRegW, ReadDataW, ALUOutW,
//                 RB_PCPlus4, A1, A2
//            out: RD1, RD2, ResultW, WriteDstW, WeW, wb_count
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31,
    parameter int COUNT_W  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_regfile_if.slave   bus
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0]  regs_q [NREG];
    logic [DATA_W-1:0]  regs_d [NREG];
    logic [COUNT_W-1:0] wb_count_q;
    logic [COUNT_W-1:0] wb_count_d;

    logic [DATA_W-1:0]  result;
    logic [ADDR_W-1:0]  dst;
    logic               we;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        if (&v) return v;
        return v + COUNT_W'(1);
    endfunction

    // Decode read with r0 forced to zero and same-cycle bypass of the
    // writeback value; the bypass can never target r0 because we excludes it.
    function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
        if (a == '0)               return '0;
        if (we && (dst == a))      return result;
        return regs_q[a];
    endfunction

    // ---- writeback select ----
    always_comb begin
        result = bus.ALUOutW;
        if (bus.LinkW)          result = bus.RB_PCPlus4;
        else if (bus.MemtoRegW) result = bus.ReadDataW;

        dst = bus.LinkW ? ADDR_W'(LINK_REG) : bus.WriteRegW;
        we  = bus.RegWriteW && (dst != '0);
    end

    // ---- next-state for register file and commit counter ----
    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[dst] = result;
        regs_d[0] = '0;
        wb_count_d = we ? sat_inc(wb_count_q) : wb_count_q;
    end

    // ---- commit edge ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            wb_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign bus.ResultW   = result;
    assign bus.WriteDstW = dst;
    assign bus.WeW       = we;
    assign bus.RD1       = rd_port(bus.A1);
    assign bus.RD2       = rd_port(bus.A2);
    assign bus.wb_count  = wb_count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
// Directed bench for wb_regfile. The counter is built 4 bits wide so that
// saturation at all-ones is reachable in a few cycles.
// ---------------------------------------------------------------------------
module tb_wb_regfile;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int COUNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .COUNT_W(COUNT_W)) bus ();

    wb_regfile #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINK_REG(31), .COUNT_W(COUNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.RegWriteW  = 1'b0;
        bus.MemtoRegW  = 1'b0;
        bus.LinkW      = 1'b0;
        bus.WriteRegW  = '0;
        bus.ReadDataW  = '0;
        bus.ALUOutW    = '0;
        bus.RB_PCPlus4 = '0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_wr(input logic [4:0] r, input logic [31:0] v);
        idle();
        bus.RegWriteW = 1'b1;
        bus.WriteRegW = r;
        bus.ALUOutW   = v;
    endtask

    initial begin
        idle();
        bus.A1 = '0;
        bus.A2 = '0;

        // Reset state: reads zero, counter zero.
        #3;
        bus.A1 = 5'd7;  bus.A2 = 5'd31; #1;
        chk("rst_rd1_r7", bus.RD1, 32'h0);
        chk("rst_rd2_r31", bus.RD2, 32'h0);
        chk("rst_count", 32'(bus.wb_count), 32'h0);

        // Bypass still forwards during reset, but the edge does not commit.
        tick();
        alu_wr(5'd3, 32'h0000_00AA);
        bus.A1 = 5'd3; #1;
        chk("rst_bypass", bus.RD1, 32'h0000_00AA);
        tick();
        idle(); #1;
        chk("rst_no_commit", bus.RD1, 32'h0);
        chk("rst_no_count", 32'(bus.wb_count), 32'h0);

        // Release reset away from an edge.
        #2 rst_n = 1'b1;

        // ALU write to r5 with same-cycle bypass.
        tick();
        alu_wr(5'd5, 32'h0000_1234);
        bus.A1 = 5'd5; #1;
        chk("alu_bypass", bus.RD1, 32'h0000_1234);
        chk("alu_wew", 32'(bus.WeW), 32'h1);
        chk("alu_dst", 32'(bus.WriteDstW), 32'd5);
        tick();
        idle(); #1;
        chk("alu_commit", bus.RD1, 32'h0000_1234);
        chk("alu_count", 32'(bus.wb_count), 32'd1);

        // Load to r8 (ALU value must not be chosen).
        alu_wr(5'd8, 32'h0000_5555);
        bus.MemtoRegW = 1'b1;
        bus.ReadDataW = 32'hDEAD_BEEF; #1;
        chk("load_result", bus.ResultW, 32'hDEAD_BEEF);
        tick();

        // Link overrides load and destination.
        alu_wr(5'd8, 32'h0000_5555);
        bus.MemtoRegW  = 1'b1;
        bus.ReadDataW  = 32'h1111_2222;
        bus.LinkW      = 1'b1;
        bus.RB_PCPlus4 = 32'h0040_0010;
        bus.A2 = 5'd31; #1;
        chk("link_dst", 32'(bus.WriteDstW), 32'd31);
        chk("link_result", bus.ResultW, 32'h0040_0010);
        chk("link_bypass", bus.RD2, 32'h0040_0010);
        tick();
        idle();
        bus.A1 = 5'd8; #1;
        chk("load_r8_kept", bus.RD1, 32'hDEAD_BEEF);
        chk("link_r31", bus.RD2, 32'h0040_0010);
        chk("link_count", 32'(bus.wb_count), 32'd3);

        // Write to r0 is dropped everywhere.
        alu_wr(5'd0, 32'h0000_FFFF);
        bus.A1 = 5'd0; #1;
        chk("r0_bypass", bus.RD1, 32'h0);
        chk("r0_wew", 32'(bus.WeW), 32'h0);
        tick();
        idle(); #1;
        chk("r0_after", bus.RD1, 32'h0);
        chk("r0_count", 32'(bus.wb_count), 32'd3);

        // Link with RegWriteW=0: no bypass and no write to r31.
        bus.LinkW      = 1'b1;
        bus.RB_PCPlus4 = 32'h1234_5678;
        bus.A2 = 5'd31; #1;
        chk("dis_wew", 32'(bus.WeW), 32'h0);
        chk("dis_no_bypass", bus.RD2, 32'h0040_0010);
        tick();
        idle(); #1;
        chk("dis_r31", bus.RD2, 32'h0040_0010);
        chk("dis_count", 32'(bus.wb_count), 32'd3);

        // Both ports on the same register.
        bus.A1 = 5'd5; bus.A2 = 5'd5; #1;
        chk("same_rd1", bus.RD1, 32'h0000_1234);
        chk("same_rd2", bus.RD2, 32'h0000_1234);

        // Counter saturation: 12 more writes reach 15, two more hold it.
        for (int i = 1; i <= 14; i++) begin
            alu_wr(5'd9, 32'(i));
            tick();
            if (i == 12) chk("cnt_at_max", 32'(bus.wb_count), 32'd15);
        end
        idle();
        bus.A1 = 5'd9; #1;
        chk("cnt_saturated", 32'(bus.wb_count), 32'd15);
        chk("r9_last", bus.RD1, 32'd14);

        // Asynchronous reset in the middle of a pending write.
        alu_wr(5'd10, 32'h0000_CAFE);
        bus.A1 = 5'd5; bus.A2 = 5'd10;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_r5_clear", bus.RD1, 32'h0);
        chk("arst_count", 32'(bus.wb_count), 32'h0);
        chk("arst_bypass", bus.RD2, 32'h0000_CAFE);
        tick();
        idle(); #1;
        chk("arst_no_write", bus.RD2, 32'h0);
        #2 rst_n = 1'b1;

        // First write after release.
        tick();
        alu_wr(5'd10, 32'h0000_BEEF);
        tick();
        idle(); #1;
        chk("post_rst_write", bus.RD2, 32'h0000_BEEF);
        chk("post_rst_count", 32'(bus.wb_count), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end
endmodule
